// File: rtl/lane_dly_step_ctrl.sv
// Per-lane DQS delay-line step sequencer: turns training commands into spaced
// MOVE/LOAD strobes for LANECTRL, with clock pause around loads and tap tracking.
module lane_dly_step_ctrl #(
    parameter int unsigned TAP_W          = 8,
    parameter int unsigned MOVE_GAP       = 4,
    parameter int unsigned PAUSE_LEAD     = 3,
    parameter int unsigned PAUSE_TRAIL    = 3,
    parameter int unsigned RX_TAP_DEFAULT = 1,
    parameter int unsigned TX_TAP_DEFAULT = 1
) (
    input  logic             FAB_CLK,
    input  logic             RESET_N,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_OP,
    input  logic             CMD_LINE,
    input  logic             CMD_DIR,
    input  logic [TAP_W-1:0] CMD_COUNT,
    input  logic             RX_DELAY_LINE_OUT_OF_RANGE,
    input  logic             TX_DELAY_LINE_OUT_OF_RANGE,
    output logic             DELAY_LINE_SEL,
    output logic             DELAY_LINE_DIRECTION,
    output logic             DELAY_LINE_MOVE,
    output logic             DELAY_LINE_LOAD,
    output logic             HS_IO_CLK_PAUSE,
    output logic             BUSY,
    output logic             DONE,
    output logic [1:0]       DONE_STATUS,
    output logic [TAP_W-1:0] RX_TAP_POS,
    output logic [TAP_W-1:0] TX_TAP_POS
);

    localparam int unsigned TMR_W = 16;
    localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(MOVE_GAP - 2);
    localparam logic [TMR_W-1:0] LEAD_LAST  = TMR_W'(PAUSE_LEAD - 1);
    localparam logic [TMR_W-1:0] TRAIL_LAST = TMR_W'(PAUSE_TRAIL - 1);
    localparam logic [TAP_W-1:0] RX_DEF     = TAP_W'(RX_TAP_DEFAULT);
    localparam logic [TAP_W-1:0] TX_DEF     = TAP_W'(TX_TAP_DEFAULT);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ZERO    = 2'b01;
    localparam logic [1:0] ST_RANGE   = 2'b10;
    localparam logic [1:0] ST_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_MOVE,
        S_GAP,
        S_PAUSE_PRE,
        S_LOAD,
        S_PAUSE_POST,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               sel_q, sel_d;
    logic               dir_q, dir_d;
    logic [TAP_W-1:0]   cnt_q, cnt_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [1:0]         status_q, status_d;
    logic [TAP_W-1:0]   rx_pos_q, rx_pos_d;
    logic [TAP_W-1:0]   tx_pos_q, tx_pos_d;
    logic [1:0]         rx_oor_q, tx_oor_q;

    logic               sel_oor;
    logic [TAP_W-1:0]   sel_pos;
    logic               sel_sat;
    logic               step_blocked;

    always_ff @(posedge FAB_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rx_oor_q <= '0;
            tx_oor_q <= '0;
        end else begin
            rx_oor_q <= {rx_oor_q[0], RX_DELAY_LINE_OUT_OF_RANGE};
            tx_oor_q <= {tx_oor_q[0], TX_DELAY_LINE_OUT_OF_RANGE};
        end
    end

    always_ff @(posedge FAB_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            sel_q    <= 1'b0;
            dir_q    <= 1'b1;
            cnt_q    <= '0;
            tmr_q    <= '0;
            status_q <= ST_OK;
            rx_pos_q <= RX_DEF;
            tx_pos_q <= TX_DEF;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            dir_q    <= dir_d;
            cnt_q    <= cnt_d;
            tmr_q    <= tmr_d;
            status_q <= status_d;
            rx_pos_q <= rx_pos_d;
            tx_pos_q <= tx_pos_d;
        end
    end

    // Pre-pulse gate: a step is refused if the line reports out-of-range or
    // the tracked position is already at the end it would move past.
    always_comb begin
        sel_oor      = sel_q ? tx_oor_q[1] : rx_oor_q[1];
        sel_pos      = sel_q ? tx_pos_q : rx_pos_q;
        sel_sat      = dir_q ? (sel_pos == '1) : (sel_pos == '0);
        step_blocked = sel_oor | sel_sat;
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        dir_d    = dir_q;
        cnt_d    = cnt_q;
        tmr_d    = tmr_q;
        status_d = status_q;
        rx_pos_d = rx_pos_q;
        tx_pos_d = tx_pos_q;

        case (state_q)
            S_IDLE: begin
                if (CMD_VALID) begin
                    if (CMD_OP[1]) begin
                        status_d = ST_ILLEGAL;
                        state_d  = S_DONE;
                    end else if (CMD_OP[0]) begin
                        sel_d   = CMD_LINE;
                        tmr_d   = '0;
                        state_d = S_PAUSE_PRE;
                    end else if (CMD_COUNT == '0) begin
                        status_d = ST_ZERO;
                        state_d  = S_DONE;
                    end else begin
                        sel_d   = CMD_LINE;
                        dir_d   = CMD_DIR;
                        cnt_d   = CMD_COUNT;
                        state_d = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                if (step_blocked) begin
                    status_d = ST_RANGE;
                    state_d  = S_DONE;
                end else begin
                    state_d = S_MOVE;
                end
            end
            S_MOVE: begin
                cnt_d = cnt_q - TAP_W'(1);
                tmr_d = '0;
                if (sel_q) begin
                    tx_pos_d = dir_q ? tx_pos_q + TAP_W'(1) : tx_pos_q - TAP_W'(1);
                end else begin
                    rx_pos_d = dir_q ? rx_pos_q + TAP_W'(1) : rx_pos_q - TAP_W'(1);
                end
                state_d = S_GAP;
            end
            S_GAP: begin
                if (tmr_q == GAP_LAST) begin
                    if (cnt_q == '0) begin
                        status_d = ST_OK;
                        state_d  = S_DONE;
                    end else if (step_blocked) begin
                        status_d = ST_RANGE;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_MOVE;
                    end
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_PAUSE_PRE: begin
                if (tmr_q == LEAD_LAST) begin
                    state_d = S_LOAD;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_LOAD: begin
                tmr_d = '0;
                if (sel_q) begin
                    tx_pos_d = TX_DEF;
                end else begin
                    rx_pos_d = RX_DEF;
                end
                state_d = S_PAUSE_POST;
            end
            S_PAUSE_POST: begin
                if (tmr_q == TRAIL_LAST) begin
                    status_d = ST_OK;
                    state_d  = S_DONE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign CMD_READY            = (state_q == S_IDLE);
    assign BUSY                 = (state_q != S_IDLE);
    assign DONE                 = (state_q == S_DONE);
    assign DONE_STATUS          = DONE ? status_q : 2'b00;
    assign DELAY_LINE_SEL       = sel_q;
    assign DELAY_LINE_DIRECTION = dir_q;
    assign DELAY_LINE_MOVE      = (state_q == S_MOVE);
    assign DELAY_LINE_LOAD      = (state_q == S_LOAD);
    assign HS_IO_CLK_PAUSE      = (state_q == S_PAUSE_PRE) || (state_q == S_LOAD) ||
                                  (state_q == S_PAUSE_POST);
    assign RX_TAP_POS           = rx_pos_q;
    assign TX_TAP_POS           = tx_pos_q;

endmodule

// File: tb/tb_lane_dly_step_ctrl.sv
// Bench for lane_dly_step_ctrl: directed and random commands against a
// transaction-level model of pulse timing, saturation and tap tracking.
module tb_lane_dly_step_ctrl;

    localparam int TW   = 4;
    localparam int G    = 4;
    localparam int PL   = 3;
    localparam int PT   = 3;
    localparam int MAXP = (1 << TW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic          cmd_line;
    logic          cmd_dir;
    logic [TW-1:0] cmd_count;
    logic          rx_oor;
    logic          tx_oor;
    logic          sel, dir, mv, ld, pause, busy, done;
    logic [1:0]    status;
    logic [TW-1:0] rx_pos, tx_pos;

    int n_tests = 0;
    int n_fail  = 0;

    int m_rx, m_tx, m_sel, m_dir;

    lane_dly_step_ctrl #(
        .TAP_W(TW),
        .MOVE_GAP(G),
        .PAUSE_LEAD(PL),
        .PAUSE_TRAIL(PT),
        .RX_TAP_DEFAULT(1),
        .TX_TAP_DEFAULT(1)
    ) dut (
        .FAB_CLK(clk),
        .RESET_N(rst_n),
        .CMD_VALID(cmd_valid),
        .CMD_READY(cmd_ready),
        .CMD_OP(cmd_op),
        .CMD_LINE(cmd_line),
        .CMD_DIR(cmd_dir),
        .CMD_COUNT(cmd_count),
        .RX_DELAY_LINE_OUT_OF_RANGE(rx_oor),
        .TX_DELAY_LINE_OUT_OF_RANGE(tx_oor),
        .DELAY_LINE_SEL(sel),
        .DELAY_LINE_DIRECTION(dir),
        .DELAY_LINE_MOVE(mv),
        .DELAY_LINE_LOAD(ld),
        .HS_IO_CLK_PAUSE(pause),
        .BUSY(busy),
        .DONE(done),
        .DONE_STATUS(status),
        .RX_TAP_POS(rx_pos),
        .TX_TAP_POS(tx_pos)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, cmd_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_move"}, mv, 0);
        check({tag, "_load"}, ld, 0);
        check({tag, "_pause"}, pause, 0);
        check({tag, "_rx"}, rx_pos, m_rx);
        check({tag, "_tx"}, tx_pos, m_tx);
        check({tag, "_sel"}, sel, m_sel);
        check({tag, "_dir"}, dir, m_dir);
    endtask

    // One command from acceptance to the first IDLE cycle, with expected
    // behaviour derived from the command rules rather than state tracking.
    task automatic run_cmd(input int op, input int line, input int d, input int cnt);
        int pos0, room, pulses, tdone, est, esel, edir, oor, np, ecur, erx, etx;
        @(negedge clk);
        check("ready_before_cmd", cmd_ready, 1);
        cmd_op    = 2'(op);
        cmd_line  = line[0];
        cmd_dir   = d[0];
        cmd_count = TW'(cnt);
        cmd_valid = 1'b1;

        oor    = line ? int'(tx_oor) : int'(rx_oor);
        pos0   = line ? m_tx : m_rx;
        pulses = 0;
        esel   = m_sel;
        edir   = m_dir;
        if (op >= 2) begin
            tdone = 1; est = 3;
        end else if (op == 1) begin
            tdone = 2 + PL + PT; est = 0; esel = line;
        end else if (cnt == 0) begin
            tdone = 1; est = 1;
        end else begin
            room   = d ? MAXP - pos0 : pos0;
            pulses = oor ? 0 : ((cnt < room) ? cnt : room);
            est    = (pulses < cnt) ? 2 : 0;
            tdone  = 2 + pulses * G;
            esel   = line;
            edir   = d;
        end

        @(posedge clk);
        for (int c = 1; c <= tdone; c++) begin
            @(negedge clk);
            if (op == 0 && cnt != 0) begin
                np   = (c <= 2) ? 0 : (((c - 3) / G + 1 < pulses) ? (c - 3) / G + 1 : pulses);
                ecur = d ? pos0 + np : pos0 - np;
            end else if (op == 1) begin
                ecur = (c > 1 + PL) ? 1 : pos0;
            end else begin
                ecur = pos0;
            end
            erx = line ? m_rx : ecur;
            etx = line ? ecur : m_tx;

            check("move", mv, (op == 0 && cnt != 0 && c >= 2 && (c - 2) % G == 0 && (c - 2) / G < pulses) ? 1 : 0);
            check("load", ld, (op == 1 && c == 1 + PL) ? 1 : 0);
            check("pause", pause, (op == 1 && c <= 1 + PL + PT) ? 1 : 0);
            check("done", done, (c == tdone) ? 1 : 0);
            check("busy", busy, 1);
            check("ready_busy", cmd_ready, 0);
            check("sel", sel, esel);
            check("dir", dir, edir);
            check("rx_pos", rx_pos, erx);
            check("tx_pos", tx_pos, etx);
            if (c == tdone) check("status", status, est);

            // Commands offered while busy must be ignored.
            if (c < tdone) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_op    = 2'($urandom_range(0, 3));
                cmd_line  = 1'($urandom_range(0, 1));
                cmd_dir   = 1'($urandom_range(0, 1));
                cmd_count = TW'($urandom_range(0, MAXP));
            end else begin
                cmd_valid = 1'b0;
            end
        end

        if (op == 0 && cnt != 0) begin
            if (line != 0) m_tx = d ? pos0 + pulses : pos0 - pulses;
            else           m_rx = d ? pos0 + pulses : pos0 - pulses;
        end else if (op == 1) begin
            if (line != 0) m_tx = 1;
            else           m_rx = 1;
        end
        m_sel = esel;
        m_dir = edir;

        @(negedge clk);
        check_idle_outputs("post_cmd");
    endtask

    initial begin
        int pulses, start, got_done, dones;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_line  = 1'b0;
        cmd_dir   = 1'b0;
        cmd_count = '0;
        rx_oor    = 1'b0;
        tx_oor    = 1'b0;
        m_rx = 1; m_tx = 1; m_sel = 0; m_dir = 1;

        repeat (3) @(negedge clk);
        check_idle_outputs("in_reset");
        check("in_reset_status", status, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("after_reset");
        check("after_reset_status", status, 0);

        run_cmd(0, 0, 1, 3);    // RX +3: 1 -> 4, DONE at t+14
        run_cmd(0, 1, 1, 8);    // TX +8: 1 -> 9
        run_cmd(1, 1, 0, 0);    // TX load from 9
        run_cmd(1, 0, 0, 0);    // RX load from 4
        run_cmd(0, 0, 0, 5);    // RX -5 from 1: one pulse then saturation
        run_cmd(2, 0, 1, 4);    // illegal op
        run_cmd(3, 1, 0, 7);    // illegal op
        run_cmd(0, 1, 1, 0);    // zero count
        run_cmd(0, 0, 1, 20 - 5); // RX +15 from 0: fills to top exactly
        run_cmd(0, 0, 1, 2);    // RX at top: no pulse

        // Out-of-range raised mid-move on TX, through the input synchroniser.
        @(negedge clk);
        start     = m_tx;
        pulses    = 0;
        got_done  = 0;
        cmd_op    = 2'b00;
        cmd_line  = 1'b1;
        cmd_dir   = 1'b1;
        cmd_count = TW'(10);
        cmd_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 100 && got_done == 0; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (mv) begin
                pulses++;
                if (pulses == 2) tx_oor = 1'b1;
            end
            if (done) begin
                got_done = 1;
                check("oor_status", status, 2);
                check("oor_tx_pos", tx_pos, start + pulses);
                check("oor_pulses_max", (pulses <= 3) ? 1 : 0, 1);
                check("oor_pulses_min", (pulses >= 2) ? 1 : 0, 1);
            end
        end
        check("oor_done_seen", got_done, 1);
        m_tx  = start + pulses;
        m_sel = 1;
        m_dir = 1;
        tx_oor = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("after_oor");

        // Randomized commands; range flags only change while idle.
        for (int i = 0; i < 70; i++) begin
            int r, op;
            @(negedge clk);
            rx_oor = ($urandom_range(0, 9) == 0);
            tx_oor = ($urandom_range(0, 9) == 0);
            repeat (3) @(negedge clk);
            r  = $urandom_range(0, 19);
            op = (r < 14) ? 0 : (r < 17) ? 1 : int'($urandom_range(2, 3));
            run_cmd(op, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, MAXP));
        end
        rx_oor = 1'b0;
        tx_oor = 1'b0;
        repeat (3) @(negedge clk);

        // Reset in the middle of a move abandons it silently.
        cmd_op    = 2'b00;
        cmd_line  = 1'b0;
        cmd_dir   = (m_rx == MAXP) ? 1'b0 : 1'b1;
        cmd_count = TW'(5);
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_rx = 1; m_tx = 1; m_sel = 0; m_dir = 1;
        check_idle_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("mid_reset_no_done", dones, 0);
        check_idle_outputs("after_mid_reset");

        run_cmd(0, 1, 0, 3);    // TX -3 from 1: one pulse then saturation
        run_cmd(0, 0, 1, 2);    // RX +2 from 1

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lane_dly_step_ctrl.md
Name: lane_dly_step_ctrl

Overview:
- Fabric-side sequencer directly upstream of the per-lane LANECTRL wrapper.
- Turns high-level training commands into correctly spaced DELAY_LINE_SEL/DIRECTION/MOVE/LOAD strobes, and asserts HS_IO_CLK_PAUSE around loads.
- Tracks the RX and TX DQS tap positions and aborts on out-of-range.
- One instance per DQS lane, driven by the DDR training engine.

Parameters:
- TAP_W, 8, width of tap counters and CMD_COUNT.
- MOVE_GAP, 4, cycles between consecutive MOVE pulses (≥2).
- PAUSE_LEAD, 3, cycles HS_IO_CLK_PAUSE is high before LOAD (≥1).
- PAUSE_TRAIL, 3, cycles HS_IO_CLK_PAUSE stays high after LOAD (≥1).
- RX_TAP_DEFAULT, 1, RX position after reset/load.
- TX_TAP_DEFAULT, 1, TX position after reset/load.

Ports:
- FAB_CLK  in  1  fabric clock; all logic on rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  high only in IDLE.
- CMD_OP  in  2  00=move, 01=load, 1x=illegal.
- CMD_LINE  in  1  0=RX DQS line, 1=TX DQS line.
- CMD_DIR  in  1  1=increment, 0=decrement.
- CMD_COUNT  in  TAP_W  number of move steps.
- RX_DELAY_LINE_OUT_OF_RANGE  in  1  from LANECTRL.
- TX_DELAY_LINE_OUT_OF_RANGE  in  1  from LANECTRL.
- DELAY_LINE_SEL  out  1  to LANECTRL.
- DELAY_LINE_DIRECTION  out  1  to LANECTRL.
- DELAY_LINE_MOVE  out  1  to LANECTRL.
- DELAY_LINE_LOAD  out  1  to LANECTRL.
- HS_IO_CLK_PAUSE  out  1  to the pause synchroniser.
- BUSY  out  1  high whenever not in IDLE.
- DONE  out  1  one-cycle completion pulse.
- DONE_STATUS  out  2  00=ok, 01=zero count, 10=range abort, 11=illegal op; valid while DONE=1.
- RX_TAP_POS  out  TAP_W  tracked RX position.
- TX_TAP_POS  out  TAP_W  tracked TX position.

Behaviour:
- Reset (async assert, sync release):
  - All strobes, PAUSE, DONE, BUSY and DONE_STATUS = 0; CMD_READY = 1.
  - DELAY_LINE_SEL = 0, DELAY_LINE_DIRECTION = 1.
  - RX_TAP_POS = RX_TAP_DEFAULT, TX_TAP_POS = TX_TAP_DEFAULT.
  - A reset mid-command abandons it with no DONE pulse.
- Both OUT_OF_RANGE inputs pass through a 2-flop synchroniser (oor_s) before use.
- States: IDLE, SETUP, MOVE, GAP, PAUSE_PRE, LOAD, PAUSE_POST, DONE.
- Command capture:
  - Accepted at edge t when CMD_VALID & CMD_READY.
  - CMD_LINE, CMD_DIR and CMD_COUNT are registered; the step counter is loaded with CMD_COUNT.
  - Inputs are ignored while BUSY.
- Illegal op, or move with CMD_COUNT=0: go directly to DONE. DONE=1 at t+1 with status 11 or 01. No strobes toggle.
- Move sequence:
  - SETUP (t+1): drive SEL=CMD_LINE and DIRECTION=CMD_DIR. Both stay stable until DONE.
  - Before each MOVE pulse, check the selected oor_s and the saturation condition (pos = 2^TAP_W-1 when incrementing, pos = 0 when decrementing). If either is true, go to DONE with status 10 and issue no further pulses.
  - MOVE pulses occur at t+2+k*MOVE_GAP for k = 0..N-1; each is exactly one cycle high.
  - The selected TAP_POS changes by ±1 on the cycle after each pulse.
  - GAP lasts MOVE_GAP-1 cycles after each pulse.
  - DONE (status 00) at t+2+N*MOVE_GAP.
- Load sequence:
  - HS_IO_CLK_PAUSE is high from t+1 through t+1+PAUSE_LEAD+PAUSE_TRAIL inclusive.
  - DELAY_LINE_LOAD is high for one cycle at t+1+PAUSE_LEAD, with SEL=CMD_LINE.
  - The selected TAP_POS is set to its default on the cycle after LOAD.
  - DONE (status 00) and PAUSE=0 at t+2+PAUSE_LEAD+PAUSE_TRAIL.
- DONE state: lasts one cycle, then IDLE (CMD_READY=1 on the next cycle). A new command may be accepted on the first IDLE cycle.
- The out-of-range flag is not checked during load; a load clears the range condition in hardware.
- MOVE and LOAD are never high in the same cycle. PAUSE is never high during a move sequence.

Test Plan:
- Reset release, then CMD_VALID held low -> CMD_READY=1, RX_TAP_POS=1, TX_TAP_POS=1, all strobes 0.
- Move, RX, inc, count 3, accepted at t (MOVE_GAP=4) -> SEL=0 and DIR=1 at t+1; MOVE pulses at t+2, t+6, t+10; RX_TAP_POS 1→4; DONE status 00 at t+14; TX_TAP_POS unchanged.
- Load, TX, after TX_TAP_POS=9, accepted at t -> PAUSE high t+1..t+7; LOAD high only at t+4 with SEL=1; TX_TAP_POS=1 from t+5; DONE status 00 and PAUSE=0 at t+8.
- Move, TX, inc, count 10, with TX_DELAY_LINE_OUT_OF_RANGE raised after the 2nd pulse -> at most 3 pulses (synchroniser latency); DONE status 10; TX_TAP_POS = start + pulses issued.
- Move, RX, dec, count 5, from RX_TAP_POS=1 -> exactly 1 pulse; RX_TAP_POS=0; DONE status 10.
- CMD_OP=10, and separately move with count 0 -> DONE at t+1 with status 11 / 01 and no strobes. Also: RESET_N pulsed mid-move -> outputs immediately 0, positions back to default, no DONE.
